// File: rtl/mux_arb_n.sv
// ============================================================================
// mux_arb_n : N-channel arbitrated mux with registered, ready/valid output
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_arb_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [1:0]             mode,
  input  logic [SELW-1:0]        force_sel,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [SELW-1:0]        out_sel,
  input  logic                   out_ready
);

  localparam logic [1:0] MODE_RR    = 2'b01;
  localparam logic [1:0] MODE_FORCE = 2'b10;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0]   elig;
  logic [2*NCH-1:0] elig2;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  shift;
  logic [SELW:0]    sum;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             found;
  logic             load_ok;
  logic             grant;

  // A force_sel beyond NCH-1 never matches any k, so nothing is eligible.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mode == MODE_FORCE) elig[k] = in_valid[k] & (force_sel == SELW'(k));
      else                    elig[k] = in_valid[k];
    end
  end

  // Rotating by the search start turns both policies into a lowest-bit search.
  assign shift = (mode == MODE_RR) ? rr_ptr_q : '0;
  assign elig2 = {elig, elig};
  assign rot   = NCH'(elig2 >> shift);

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, shift} + (SELW+1)'(j);
      end
    end
    if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
    gnt_idx = sum[SELW-1:0];
  end

  assign load_ok = ~out_valid_q | out_ready;
  assign grant   = found & load_ok & ~reset;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == SELW'(k)) begin
        in_ready[k] = grant;
        gnt_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      if (mode == MODE_RR)
        rr_ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n.sv
// ============================================================================
// tb_mux_arb_n : bench for mux_arb_n (NCH=4 and NCH=3 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [1:0]  force_sel;
  logic        out_ready;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic [1:0]  out_sel4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_sel3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode), .force_sel(force_sel),
    .out_data(out_data4), .out_valid(out_valid4), .out_sel(out_sel4),
    .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode), .force_sel(force_sel),
    .out_data(out_data3), .out_valid(out_valid3), .out_sel(out_sel3),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: grant chosen from the policy rules with plain modulo arithmetic.
  function automatic int model_grant(input int nch, input logic [1:0] md,
                                     input int fsel, input int vb, input int rr);
    if (md == 2'b10) return (fsel < nch && vb[fsel]) ? fsel : -1;
    if (md == 2'b01) begin
      for (int i = 0; i < nch; i++)
        if (vb[(rr + i) % nch]) return (rr + i) % nch;
      return -1;
    end
    for (int c = 0; c < nch; c++) if (vb[c]) return c;
    return -1;
  endfunction

  int mv[2], md[2], ms[2], mrr[2];
  int pv[2], pd[2], ps[2], prr[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; md[d] = 0; ms[d] = 0; mrr[d] = 0;
      pv[d] = 0; pd[d] = 0; ps[d] = 0; prr[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int nch, vb, g, load, exp_rdy, rdy, ov, od, os;
      nch  = (d == 0) ? 4 : 3;
      vb   = (d == 0) ? int'(in_valid4)  : int'(in_valid3);
      rdy  = (d == 0) ? int'(in_ready4)  : int'(in_ready3);
      ov   = (d == 0) ? int'(out_valid4) : int'(out_valid3);
      od   = (d == 0) ? int'(out_data4)  : int'(out_data3);
      os   = (d == 0) ? int'(out_sel4)   : int'(out_sel3);
      if (reset) begin
        mv[d] = 0; md[d] = 0; ms[d] = 0; mrr[d] = 0;
      end
      g       = model_grant(nch, mode, int'(force_sel), vb, mrr[d]);
      load    = (mv[d] == 0 || out_ready) ? 1 : 0;
      exp_rdy = (!reset && load != 0 && g >= 0) ? (1 << g) : 0;
      chk((d == 0) ? "in_ready4" : "in_ready3", rdy, exp_rdy);
      chk((d == 0) ? "out_valid4" : "out_valid3", ov, mv[d]);
      chk((d == 0) ? "out_data4" : "out_data3", od, md[d]);
      chk((d == 0) ? "out_sel4" : "out_sel3", os, ms[d]);
      pv[d] = mv[d]; pd[d] = md[d]; ps[d] = ms[d]; prr[d] = mrr[d];
      if (exp_rdy != 0) begin
        pv[d] = 1;
        pd[d] = (d == 0) ? int'(in_data4[g*8 +: 8]) : int'(in_data3[g*8 +: 8]);
        ps[d] = g;
        if (mode == 2'b01) prr[d] = (g + 1) % nch;
      end else if (out_ready) begin
        pv[d] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mv[d] = 0; md[d] = 0; ms[d] = 0; mrr[d] = 0;
      end else begin
        mv[d] = pv[d]; md[d] = pd[d]; ms[d] = ps[d]; mrr[d] = prr[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data4(input logic [7:0] base);
    for (int k = 0; k < 4; k++) in_data4[k*8 +: 8] = base + 8'(k);
  endtask

  logic [7:0] rr_exp [5];
  int         sel3_exp [4];

  initial begin
    rr_exp   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    sel3_exp = '{0, 1, 2, 0};
    reset = 1'b1; mode = 2'b00; force_sel = 2'd0; out_ready = 1'b1;
    in_data4 = '0; in_valid4 = 4'b1111; in_data3 = '0; in_valid3 = 3'b000;
    set_data4(8'hA0);
    step(); step();
    chk("rst_out_valid", int'(out_valid4), 0);
    chk("rst_out_data", int'(out_data4), 0);
    chk("rst_in_ready", int'(in_ready4), 0);
    in_valid4 = 4'b0000;
    reset = 1'b0;
    step();

    // Fixed priority
    in_valid4 = 4'b1010;
    #2 chk("prio_in_ready", int'(in_ready4), 4'b0010);
    step();
    chk("prio_sel1", int'(out_sel4), 1);
    chk("prio_data1", int'(out_data4), 8'hA1);
    in_valid4 = 4'b1000;
    #2 chk("prio_in_ready3", int'(in_ready4), 4'b1000);
    step();
    chk("prio_sel3", int'(out_sel4), 3);
    chk("prio_data3", int'(out_data4), 8'hA3);
    in_valid4 = 4'b0000;
    step();
    chk("prio_drain", int'(out_valid4), 0);

    // Round-robin
    set_data4(8'h10);
    mode = 2'b01; in_valid4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq", int'(out_data4), int'(rr_exp[i]));
    end
    in_valid4 = 4'b0000;
    step();

    // Forced
    set_data4(8'hA0);
    mode = 2'b10; force_sel = 2'd2; in_valid4 = 4'b1111;
    #2 chk("force_in_ready", int'(in_ready4), 4'b0100);
    step();
    chk("force_sel2", int'(out_sel4), 2);
    step();
    chk("force_sel2_again", int'(out_sel4), 2);
    in_valid4 = 4'b1011;
    #2 chk("force_none_ready", int'(in_ready4), 0);
    step();
    chk("force_valid_fall", int'(out_valid4), 0);

    // Backpressure
    mode = 2'b00; in_valid4 = 4'b1111; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", int'(out_data4), 8'hA0);
      chk("bp_sel", int'(out_sel4), 0);
      chk("bp_in_ready", int'(in_ready4), 0);
    end
    in_valid4 = 4'b1110; out_ready = 1'b1;
    step();
    chk("bp_release_valid", int'(out_valid4), 1);
    chk("bp_release_sel", int'(out_sel4), 1);

    // Reset mid-stream; rr pointer was left at 1 by the round-robin run
    set_data4(8'h10);
    mode = 2'b01; in_valid4 = 4'b1111;
    step();
    chk("rr_resume_sel", int'(out_sel4), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid4), 0);
    chk("midrst_data", int'(out_data4), 0);
    chk("midrst_ready", int'(in_ready4), 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_sel", int'(out_sel4), 0);
    chk("post_rst_data", int'(out_data4), 8'h10);
    in_valid4 = 4'b0000;
    step();

    // NCH=3 instance
    for (int k = 0; k < 3; k++) in_data3[k*8 +: 8] = 8'h30 + 8'(k);
    in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n3_rr_sel", int'(out_sel3), sel3_exp[i]);
    end
    mode = 2'b10; force_sel = 2'd3;
    #2 chk("n3_force3_ready", int'(in_ready3), 0);
    step();
    chk("n3_force3_valid", int'(out_valid3), 0);
    mode = 2'b11; in_valid3 = 3'b110;
    #2 chk("n3_mode11_ready", int'(in_ready3), 3'b010);
    step();
    chk("n3_mode11_sel", int'(out_sel3), 1);
    in_valid3 = 3'b000;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
